dm_arbiter: RTL

- Two-port round-robin arbiter and sequencer in front of the byte-addressed, big-endian 128-byte data memory.
- Requesters: core load/store unit (port 0) and debug/DMA loader (port 1).
- Each request is accepted with a valid/ready handshake, then run as a single word access to the DM. The result returns on a one-cycle response strobe to the winning requester.

---
 rtl/dm_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter/sequencer for the 128-byte big-endian data memory.
// Optional address check enabled by defining DM_ARB_ADDR_CHECK_EN.
module dm_arbiter #(
  parameter int DM_SIZE = 128,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic              req_we0,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [31:0]       req_wdata0,
  input  logic              req_we1,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [31:0]       req_wdata1,
  output logic [1:0]        resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] Mem_addr,
  output logic [31:0]       Mem_w_data,
  output logic              Mem_w,
  output logic              Mem_r,
  input  logic [31:0]       Mem_r_data,
  output logic [1:0]        dbg_state,
  output logic              dbg_rr
);

`ifdef DM_ARB_ADDR_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DM_SIZE - 4);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                rr_q, win_q, we_q, flag_q, err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q, rdata_q;
  logic [1:0]          grant;
  logic                sel_we, addr_bad;
  logic [ADDR_W-1:0]   sel_addr;
  logic [31:0]         sel_wdata;

  // Handshake: a request transfers on the posedge where req_valid[i] & req_ready[i];
  // ready is offered only in IDLE, to at most one port, and never during reset.
  always_comb begin
    grant = 2'b00;
    if (rst && state_q == IDLE) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;
  assign sel_we    = grant[1] ? req_we1    : req_we0;
  assign sel_addr  = grant[1] ? req_addr1  : req_addr0;
  assign sel_wdata = grant[1] ? req_wdata1 : req_wdata0;
  assign addr_bad  = (sel_addr[1:0] != 2'b00) || (sel_addr > LAST_WORD);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|grant) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      flag_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (|grant) begin
        win_q   <= grant[1];
        rr_q    <= ~grant[1];
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        flag_q  <= CHECK_EN & addr_bad;
      end
      // Writes and rejected requests return zero data.
      if (state_q == ACCESS) begin
        rdata_q <= (we_q || flag_q) ? 32'd0 : Mem_r_data;
        err_q   <= flag_q;
      end
    end
  end

  // Memory-side outputs are forced to zero outside ACCESS so reset drops them at once.
  assign Mem_addr   = (state_q == ACCESS) ? addr_q  : '0;
  assign Mem_w_data = (state_q == ACCESS) ? wdata_q : '0;
  assign Mem_w      = (state_q == ACCESS) &  we_q & ~flag_q;
  assign Mem_r      = (state_q == ACCESS) & ~we_q & ~flag_q;

  assign resp_valid = (state_q == RESP) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
  assign resp_rdata = rdata_q;
  assign resp_err   = CHECK_EN & err_q;

  assign dbg_state  = state_q;
  assign dbg_rr     = rr_q;

endmodule
